// File: rtl/icache_pkg.sv
// icache_pkg: shared types, widths and constants
// for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic int off_bits(input int bw);
    return $clog2(bw);
  endfunction

  function automatic int idx_bits(input int ns);
    return $clog2(ns);
  endfunction

  function automatic int tag_bits(input int ns, input int bw);
    return 30 - $clog2(ns) - $clog2(bw);
  endfunction

endpackage

// File: rtl/icache_data_array.sv
// icache_data_array: NUM_SETS x BLOCK_WORDS x 32
// storage, async read, sync single-word write.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS    = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(NUM_SETS)-1:0]    widx,
  input  logic [$clog2(BLOCK_WORDS)-1:0] woff,
  input  logic [31:0]                    wdata,
  input  logic [$clog2(NUM_SETS)-1:0]    ridx,
  input  logic [$clog2(BLOCK_WORDS)-1:0] roff,
  output logic [31:0]                    rdata
);

  logic [31:0] mem_q [NUM_SETS][BLOCK_WORDS];

  // Fill beats land one word at a time
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[widx][woff] <= wdata;
    end
  end

  assign rdata = mem_q[ridx][roff];

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only I-cache,
// zero-latency hit, in-order block fill on miss.
module icache_dm
  import icache_pkg::*;
#(
  parameter int NUM_SETS    = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_valid,
  output logic [31:0] miss_count
);

  localparam int OB = off_bits(BLOCK_WORDS);
  localparam int IB = idx_bits(NUM_SETS);
  localparam int TB = tag_bits(NUM_SETS, BLOCK_WORDS);

  logic [OB-1:0] pc_off;
  logic [IB-1:0] pc_idx;
  logic [TB-1:0] pc_tag;
  logic [1:0]    unused_pc;

  assign pc_off    = pc[OB+1:2];
  assign pc_idx    = pc[OB+2 +: IB];
  assign pc_tag    = pc[31 -: TB];
  assign unused_pc = pc[1:0];

  icache_state_t state_q, state_d;
  logic [OB-1:0]       cnt_q, cnt_d;
  logic [31:0]         blk_base_q, blk_base_d;
  logic [31:0]         miss_count_q, miss_count_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TB-1:0]       tag_q [NUM_SETS];

  logic [IB-1:0] fill_idx;
  logic [TB-1:0] fill_tag;
  logic          hit;
  logic          beat;
  logic          last;
  logic [31:0]   rdata;

  assign fill_idx = blk_base_q[OB+2 +: IB];
  assign fill_tag = blk_base_q[31 -: TB];

  assign hit = (state_q == IDLE) &&
               valid_q[pc_idx] &&
               (tag_q[pc_idx] == pc_tag);

  assign beat = (state_q == FILL) && mem_valid;
  assign last = beat &&
                (cnt_q == OB'(BLOCK_WORDS - 1));

  icache_data_array #(
    .NUM_SETS    (NUM_SETS),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_data (
    .clk   (clk),
    .we    (beat),
    .widx  (fill_idx),
    .woff  (cnt_q),
    .wdata (mem_rdata),
    .ridx  (pc_idx),
    .roff  (pc_off),
    .rdata (rdata)
  );

  // Next state, fill bookkeeping and memory port
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    blk_base_d   = blk_base_q;
    miss_count_d = miss_count_q;
    valid_d      = valid_q;
    mem_req      = 1'b0;
    mem_addr     = 32'h0;
    unique case (state_q)
      IDLE: begin
        if (!hit) begin
          blk_base_d   = {pc[31:OB+2],
                          {(OB+2){1'b0}}};
          cnt_d        = '0;
          miss_count_d = miss_count_q + 32'd1;
          state_d      = FILL;
        end
      end
      FILL: begin
        mem_req  = 1'b1;
        mem_addr = blk_base_q +
                   {{(30-OB){1'b0}}, cnt_q, 2'b00};
        if (mem_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (last) begin
            valid_d[fill_idx] = 1'b1;
            state_d           = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state; only valid bits are cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      blk_base_q   <= 32'h0;
      miss_count_q <= 32'h0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      blk_base_q   <= blk_base_d;
      miss_count_q <= miss_count_d;
      valid_q      <= valid_d;
    end
  end

  // Tag is committed with the final beat
  always_ff @(posedge clk) begin
    if (last && !reset) begin
      tag_q[fill_idx] <= fill_tag;
    end
  end

  assign instr      = hit ? rdata : NOP;
  assign stall      = !hit;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed tables, hand sequences
// and random fetches against a line-level model.
module tb_icache_dm;

  localparam int NS = 16;
  localparam int BW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  icache_dm #(
    .NUM_SETS    (NS),
    .BLOCK_WORDS (BW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .instr      (instr),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .miss_count (miss_count)
  );

  // Main memory contents: word at byte a
  function automatic logic [31:0] memfn(
    input logic [31:0] a);
    return 32'hA0 + (a >> 2);
  endfunction

  assign mem_rdata = memfn(mem_addr);

  // Line-level reference model
  bit          m_valid [NS];
  int unsigned m_tag   [NS];
  int unsigned mc;

  int n_chk  = 0;
  int n_pass = 0;
  logic pat[$];

  function automatic int unsigned midx(
    input logic [31:0] p);
    return (p / (4 * BW)) % NS;
  endfunction

  function automatic int unsigned mtg(
    input logic [31:0] p);
    return p / (4 * BW * NS);
  endfunction

  function automatic bit mhit(input logic [31:0] p);
    return m_valid[midx(p)] && m_tag[midx(p)] == mtg(p);
  endfunction

  function automatic void mclear();
    for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
    mc = 0;
  endfunction

  function automatic logic [71:0] pk(
    input logic s, input logic r,
    input logic [31:0] i, input logic [31:0] a);
    return {3'b0, s, 3'b0, r, i, a};
  endfunction

  function automatic logic [71:0] obs();
    return pk(stall, mem_req, instr, mem_addr);
  endfunction

  task automatic chk(input string nm,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, got, exp);
  endtask

  task automatic drive(input logic [31:0] p,
                       input logic v);
    pc = p;
    mem_valid = v;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Miss: detect cycle, then beats until the block is in
  task automatic do_fill(input logic [31:0] p,
                         input int chg,
                         input logic [31:0] p2,
                         output int ncyc);
    logic [31:0] base;
    logic [31:0] cur;
    logic v;
    int beats;
    int guard;
    cur = p;
    drive(cur, 1'b1);
    chk("detect", obs(), pk(1'b1, 1'b0, 32'h0, 32'h0));
    chk("detect_mcnt", 72'(miss_count), 72'(mc));
    step();
    mc++;
    base  = p - (p % (4 * BW));
    beats = 0;
    guard = 0;
    ncyc  = 1;
    while (beats < BW && guard < 200) begin
      if (chg >= 0 && beats == chg) cur = p2;
      if (pat.size() > 0) v = pat.pop_front();
      else v = ($urandom % 4) != 0;
      drive(cur, v);
      chk("fill", obs(),
          pk(1'b1, 1'b1, 32'h0, 32'(base + 4 * beats)));
      if (v) beats++;
      ncyc++;
      guard++;
      step();
    end
    if (guard >= 200) begin
      n_chk++;
      $display("FAIL fill_timeout: got %0d beats required %0d",
               beats, BW);
    end
    m_valid[midx(base)] = 1'b1;
    m_tag[midx(base)]   = mtg(base);
    chk("fill_mcnt", 72'(miss_count), 72'(mc));
  endtask

  // One fetch: fill if the model says miss, then hit
  task automatic access(input logic [31:0] p);
    int n;
    if (!mhit(p)) do_fill(p, -1, p, n);
    drive(p, 1'($urandom % 2));
    chk("hit", obs(), pk(1'b0, 1'b0, memfn(p), 32'h0));
    chk("hit_mcnt", 72'(miss_count), 72'(mc));
    step();
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        stall;
    logic [31:0] instr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    int n;
    tbl[0] = '{32'h4, 1'b0, 32'hA1};
    tbl[1] = '{32'h8, 1'b0, 32'hA2};
    tbl[2] = '{32'hC, 1'b0, 32'hA3};
    tbl[3] = '{32'h5, 1'b0, 32'hA1};
    tbl[4] = '{32'h0, 1'b0, 32'hA0};

    reset = 1'b1;
    pc = 32'h0;
    mem_valid = 1'b0;
    step();
    step();
    chk("reset_out", obs(), pk(1'b1, 1'b0, 32'h0, 32'h0));
    chk("reset_mcnt", 72'(miss_count), 72'(0));
    reset = 1'b0;
    mclear();

    // Cold miss with zero-wait memory
    pat = '{1'b1, 1'b1, 1'b1, 1'b1};
    do_fill(32'h0, -1, 32'h0, n);
    chk("cold_stall_cycles", 72'(n), 72'(5));
    access(32'h0);
    chk("cold_mcnt", 72'(miss_count), 72'(1));

    // Hits inside the block, same cycle
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].pc, 1'b0);
      chk("tbl_hit", obs(),
          pk(tbl[i].stall, 1'b0, tbl[i].instr, 32'h0));
      step();
    end

    // Conflict eviction and return
    access(32'h100);
    chk("conflict_mcnt", 72'(miss_count), 72'(2));
    access(32'h0);
    chk("return_mcnt", 72'(miss_count), 72'(3));

    // Wait states between beats
    pat = '{1'b1, 1'b0, 1'b0, 1'b1,
            1'b0, 1'b1, 1'b1};
    do_fill(32'h30, -1, 32'h30, n);
    chk("wait_stall_cycles", 72'(n), 72'(8));
    access(32'h30);
    access(32'h3C);

    // pc moves away mid-fill
    pat = '{1'b1, 1'b1, 1'b1, 1'b1};
    do_fill(32'h20, 2, 32'h44, n);
    access(32'h44);
    access(32'h20);
    access(32'h2C);

    // Reset after beat 2 of a fill
    drive(32'h50, 1'b1);
    step();
    drive(32'h50, 1'b1);
    step();
    drive(32'h50, 1'b1);
    chk("pre_reset_fill", obs(),
        pk(1'b1, 1'b1, 32'h0, 32'h54));
    step();
    reset = 1'b1;
    drive(32'h50, 1'b1);
    step();
    reset = 1'b0;
    mclear();
    chk("post_reset_req", 72'(mem_req), 72'(0));
    do_fill(32'h50, -1, 32'h50, n);
    access(32'h50);
    access(32'h0);

    // Random fetches over a few conflicting tags
    for (int i = 0; i < 80; i++) begin
      access($urandom % (4 * BW * NS * 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
